// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : if_pkg
// Purpose  : Shared types and constants for the instruction-fetch unit.
//            fetch_state_t - fetch FSM state encoding (2 bits)
//            NOP_INSTR     - canonical NOP (addi x0,x0,0)
//            PC_INCR       - sequential PC step
// Revision : 1.0 - initial release
// ============================================================================
package if_pkg;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,   // address phase: imem_req asserted
        WAIT    = 2'd1,   // granted, waiting for the response
        HOLD    = 2'd2,   // instruction buffered and presented to decode
        DISCARD = 2'd3    // a redirect made the outstanding response stale
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INCR   = 32'd4;

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : Fetch-stage engine feeding the F side of the IF/ID register.
//            Owns the PC, runs a one-outstanding req/gnt/rvalid handshake
//            to instruction memory, buffers the fetched instruction while
//            decode stalls and applies execute-stage redirects, dropping
//            responses that a redirect made stale.
// Ports    : clk, rst (sync, active-high)
//            stall_f, pc_src_e, pc_target_e[31:0]   - hazard / execute
//            imem_req, imem_addr[31:0]              - request to imem
//            imem_gnt, imem_rvalid, imem_rdata[31:0]- imem handshake
//            pc_f, pc_plus_4_f, instr_f, instr_valid_f - to IF/ID register
//            fetch_cnt, stall_cnt                   - only with the macro
// Config   : `define IF_FETCH_PERF_CNT_EN adds the handoff and stall
//            counters (fetch_cnt / stall_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] pc_plus_4_f,
    output logic [31:0] instr_f,
    output logic        instr_valid_f
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    fetch_state_t r_state_q;
    fetch_state_t w_state_d;
    logic [31:0]  r_pc_q;
    logic [31:0]  w_pc_d;
    logic [31:0]  r_instr_q;
    logic [31:0]  w_instr_d;
    logic         r_valid_q;
    logic         w_valid_d;

    logic [31:0]  w_redirect_pc;
    logic         w_unused_tgt_lsbs;

    // Redirect targets are word aligned; the low bits are dropped.
    assign w_redirect_pc     = {pc_target_e[31:2], 2'b00};
    assign w_unused_tgt_lsbs = ^pc_target_e[1:0];

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_instr_d = r_instr_q;
        w_valid_d = r_valid_q;

        // A redirect always wins the PC, whatever the state.
        if (pc_src_e) begin
            w_pc_d = w_redirect_pc;
        end

        case (r_state_q)
            ISSUE: begin
                // Ungranted request simply re-presents the (possibly new) PC.
                if (imem_gnt) begin
                    w_state_d = pc_src_e ? DISCARD : WAIT;
                end
            end
            WAIT: begin
                if (pc_src_e) begin
                    // Response arriving now is for the old PC: drop it.
                    w_state_d = imem_rvalid ? ISSUE : DISCARD;
                end else if (imem_rvalid) begin
                    w_instr_d = imem_rdata;
                    w_valid_d = 1'b1;
                    w_state_d = HOLD;
                end
            end
            HOLD: begin
                if (pc_src_e) begin
                    w_instr_d = NOP_INSTR;
                    w_valid_d = 1'b0;
                    w_state_d = ISSUE;
                end else if (!stall_f) begin
                    // Handoff: IF/ID captures this edge, move to next word.
                    w_pc_d    = r_pc_q + PC_INCR;
                    w_instr_d = NOP_INSTR;
                    w_valid_d = 1'b0;
                    w_state_d = ISSUE;
                end
            end
            DISCARD: begin
                if (imem_rvalid) begin
                    w_state_d = ISSUE;
                end
            end
            default: begin
                w_state_d = ISSUE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ISSUE;
            r_pc_q    <= RESET_PC;
            r_instr_q <= NOP_INSTR;
            r_valid_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_instr_q <= w_instr_d;
            r_valid_q <= w_valid_d;
        end
    end

    // Request is masked during reset so nothing is issued in the reset cycle.
    assign imem_req      = (r_state_q == ISSUE) && !rst;
    assign imem_addr     = r_pc_q;
    assign pc_f          = r_pc_q;
    assign pc_plus_4_f   = r_pc_q + PC_INCR;
    assign instr_f       = r_instr_q;
    assign instr_valid_f = r_valid_q;

`ifdef IF_FETCH_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic        w_handoff;
    logic        w_hold_stall;
    logic [31:0] r_fetch_cnt_q;
    logic [31:0] w_fetch_cnt_d;
    logic [31:0] r_stall_cnt_q;
    logic [31:0] w_stall_cnt_d;

    assign w_handoff    = (r_state_q == HOLD) && !stall_f && !pc_src_e;
    assign w_hold_stall = (r_state_q == HOLD) &&  stall_f && !pc_src_e;

    always_comb begin
        w_fetch_cnt_d = r_fetch_cnt_q;
        w_stall_cnt_d = r_stall_cnt_q;
        if (w_handoff) begin
            w_fetch_cnt_d = r_fetch_cnt_q + 32'd1;
        end
        if (w_hold_stall) begin
            w_stall_cnt_d = r_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt_q <= 32'd0;
            r_stall_cnt_q <= 32'd0;
        end else begin
            r_fetch_cnt_q <= w_fetch_cnt_d;
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    assign fetch_cnt = r_fetch_cnt_q;
    assign stall_cnt = r_stall_cnt_q;
`endif

`ifndef SYNTHESIS
    // Responses may only arrive while one is outstanding.
    a_rvalid_in_window: assert property (
        @(posedge clk) disable iff (rst)
        imem_rvalid |-> (r_state_q == WAIT || r_state_q == DISCARD));
`endif

endmodule

`default_nettype wire
